// File: rtl/pipelined_cla_adder_if.sv
// Operand/result handshake bundle for the pipelined carry-lookahead adder.
// The master drives operands and accepts results; the slave is the adder.
interface pipelined_cla_adder_if #(
   parameter int WIDTH = 32
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             cin;
   logic             sub;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] f;
   logic             cout;
   logic             ovf;
   logic             zero;

   modport master (
      output in_valid, a, b, cin, sub, out_ready,
      input  in_ready, out_valid, f, cout, ovf, zero
   );

   modport slave (
      input  in_valid, a, b, cin, sub, out_ready,
      output in_ready, out_valid, f, cout, ovf, zero
   );
endinterface

// File: rtl/pipelined_cla_adder.sv
// Pipelined carry-lookahead adder/subtractor: one SLICE-bit slice resolved per stage,
// 4-bit lookahead groups chained inside each slice, valid/ready backpressure on both sides.
module pipelined_cla_adder #(
   parameter int WIDTH = 32,
   parameter int SLICE = 8
) (
   input  logic                 clk,
   input  logic                 rst_n,
   pipelined_cla_adder_if.slave bus
);
   localparam int STAGES = WIDTH / SLICE;

   // Returns {carry into slice MSB, carry out of slice, slice sum}.
   function automatic logic [SLICE+1:0] cla_slice(input logic [SLICE-1:0] x,
                                                  input logic [SLICE-1:0] y,
                                                  input logic             ci);
      logic [SLICE-1:0] g, p, s;
      logic [SLICE:0]   c;
      g    = x & y;
      p    = x | y;
      c    = '0;
      c[0] = ci;
      for (int j = 0; j < SLICE / 4; j++) begin
         c[4*j+1] = g[4*j] | (p[4*j] & c[4*j]);
         c[4*j+2] = g[4*j+1] | (p[4*j+1] & g[4*j]) | (p[4*j+1] & p[4*j] & c[4*j]);
         c[4*j+3] = g[4*j+2] | (p[4*j+2] & g[4*j+1]) | (p[4*j+2] & p[4*j+1] & g[4*j])
                  | (p[4*j+2] & p[4*j+1] & p[4*j] & c[4*j]);
         c[4*j+4] = g[4*j+3] | (p[4*j+3] & g[4*j+2]) | (p[4*j+3] & p[4*j+2] & g[4*j+1])
                  | (p[4*j+3] & p[4*j+2] & p[4*j+1] & g[4*j])
                  | (p[4*j+3] & p[4*j+2] & p[4*j+1] & p[4*j] & c[4*j]);
      end
      s = x ^ y ^ c[SLICE-1:0];
      return {c[SLICE-1], c[SLICE], s};
   endfunction

   logic [STAGES-1:0]            vld_q, vld_d;
   logic [STAGES-1:0]            c_q, c_d;
   logic [STAGES-1:0][WIDTH-1:0] a_q, a_d;
   logic [STAGES-1:0][WIDTH-1:0] b_q, b_d;
   logic [STAGES-1:0][WIDTH-1:0] res_q, res_d;
   logic                         ovf_q, ovf_d;
   logic                         zero_q, zero_d;

   logic [STAGES:0]  adv;
   logic             src_v, src_c;
   logic [WIDTH-1:0] src_a, src_b, src_r;
   logic [SLICE+1:0] slc;

   always_comb begin
      vld_d  = vld_q;
      c_d    = c_q;
      a_d    = a_q;
      b_d    = b_q;
      res_d  = res_q;
      ovf_d  = ovf_q;
      zero_d = zero_q;
      src_v  = 1'b0;
      src_c  = 1'b0;
      src_a  = '0;
      src_b  = '0;
      src_r  = '0;
      slc    = '0;

      // A stage may move when it is empty or the stage after it moves.
      adv[STAGES] = bus.out_ready;
      for (int k = STAGES - 1; k >= 0; k--)
         adv[k] = !vld_q[k] | adv[k+1];

      for (int k = 0; k < STAGES; k++) begin
         if (k == 0) begin
            src_v = bus.in_valid;
            src_a = bus.a;
            src_b = bus.sub ? ~bus.b : bus.b;
            src_c = bus.sub | bus.cin;
            src_r = '0;
         end else begin
            src_v = vld_q[k-1];
            src_a = a_q[k-1];
            src_b = b_q[k-1];
            src_c = c_q[k-1];
            src_r = res_q[k-1];
         end
         slc = cla_slice(src_a[k*SLICE +: SLICE], src_b[k*SLICE +: SLICE], src_c);
         if (adv[k]) begin
            vld_d[k]                    = src_v;
            a_d[k]                      = src_a;
            b_d[k]                      = src_b;
            c_d[k]                      = slc[SLICE];
            res_d[k]                    = src_r;
            res_d[k][k*SLICE +: SLICE]  = slc[SLICE-1:0];
            if (k == STAGES - 1) begin
               ovf_d  = slc[SLICE+1] ^ slc[SLICE];
               zero_d = ~|res_d[k];
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld_q  <= '0;
         c_q    <= '0;
         a_q    <= '0;
         b_q    <= '0;
         res_q  <= '0;
         ovf_q  <= 1'b0;
         zero_q <= 1'b0;
      end else begin
         vld_q  <= vld_d;
         c_q    <= c_d;
         a_q    <= a_d;
         b_q    <= b_d;
         res_q  <= res_d;
         ovf_q  <= ovf_d;
         zero_q <= zero_d;
      end
   end

   assign bus.in_ready  = adv[0];
   assign bus.out_valid = vld_q[STAGES-1];
   assign bus.f         = res_q[STAGES-1];
   assign bus.cout      = c_q[STAGES-1];
   assign bus.ovf       = ovf_q;
   assign bus.zero      = zero_q;
endmodule

// File: tb/tb_pipelined_cla_adder.sv
// Randomised and directed bench for pipelined_cla_adder against a 33-bit arithmetic model.
module tb_pipelined_cla_adder;
   localparam int W  = 32;
   localparam int SL = 8;
   localparam int ST = W / SL;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   pipelined_cla_adder_if #(.WIDTH(W)) bus ();
   pipelined_cla_adder #(.WIDTH(W), .SLICE(SL)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

   int n_cmp = 0;
   int n_err = 0;
   int n_rx  = 0;
   logic [W+2:0] exp_q[$];

   // {cout, ovf, zero, f} from plain wide arithmetic.
   function automatic logic [W+2:0] ref_model(input logic [W-1:0] a, input logic [W-1:0] b,
                                              input logic cin, input logic sub);
      logic [W-1:0] bb;
      logic [W:0]   s;
      logic         ci, ov;
      bb = sub ? ~b : b;
      ci = sub ? 1'b1 : cin;
      s  = {1'b0, a} + {1'b0, bb} + {{W{1'b0}}, ci};
      ov = (a[W-1] == bb[W-1]) && (s[W-1] != a[W-1]);
      return {s[W], ov, (s[W-1:0] == '0), s[W-1:0]};
   endfunction

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Scoreboard: every presented result must equal the oldest outstanding beat.
   always @(negedge clk) begin
      if (!rst_n) exp_q.delete();
      else begin
         if (bus.out_valid) begin
            check("out_expected", 64'(exp_q.size() != 0), 64'd1);
            if (exp_q.size() != 0) begin
               check("result", 64'({bus.cout, bus.ovf, bus.zero, bus.f}), 64'(exp_q[0]));
               if (bus.out_ready) begin
                  void'(exp_q.pop_front());
                  n_rx++;
               end
            end
         end
         if (bus.in_valid && bus.in_ready)
            exp_q.push_back(ref_model(bus.a, bus.b, bus.cin, bus.sub));
      end
   end

   task automatic rand_beat();
      bus.a   = $urandom;
      bus.b   = $urandom;
      bus.cin = 1'($urandom_range(0, 1));
      bus.sub = 1'($urandom_range(0, 1));
   endtask

   task automatic directed(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic cin, input logic sub, input logic [W-1:0] ef,
                           input logic ec, input logic eo, input logic ez);
      int lat;
      bus.a = a; bus.b = b; bus.cin = cin; bus.sub = sub; bus.in_valid = 1'b1;
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      lat = 0;
      do begin
         @(negedge clk);
         lat++;
      end while (!bus.out_valid && lat < 20);
      check({tag, "_lat"},  64'(lat), 64'(ST));
      check({tag, "_f"},    64'(bus.f), 64'(ef));
      check({tag, "_cout"}, 64'(bus.cout), 64'(ec));
      check({tag, "_ovf"},  64'(bus.ovf), 64'(eo));
      check({tag, "_zero"}, 64'(bus.zero), 64'(ez));
      @(posedge clk); #1;
   endtask

   task automatic drain(input string tag, input int rx0, input int expected);
      for (int t = 0; t < 60 && exp_q.size() != 0; t++) @(negedge clk);
      check({tag, "_rx"}, 64'(n_rx - rx0), 64'(expected));
      @(posedge clk); #1;
   endtask

   initial begin
      int rx0, acc_cnt;
      logic acc;
      bus.in_valid = 1'b0; bus.a = '0; bus.b = '0; bus.cin = 1'b0; bus.sub = 1'b0;
      bus.out_ready = 1'b1;

      @(negedge clk);
      check("rst_out_valid", 64'(bus.out_valid), 64'd0);
      check("rst_f",         64'(bus.f), 64'd0);
      check("rst_flags",     64'({bus.cout, bus.ovf, bus.zero}), 64'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(negedge clk);
      check("rst_in_ready", 64'(bus.in_ready), 64'd1);
      @(posedge clk); #1;

      directed("add_wrap",  32'hFFFF_FFFF, 32'h1, 1'b0, 1'b0, 32'h0,         1'b1, 1'b0, 1'b1);
      directed("sub_neg",   32'h5,         32'h7, 1'b0, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0);
      directed("sub_ovf",   32'h8000_0000, 32'h1, 1'b1, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0);
      directed("carry_x",   32'h00FF_FFFF, 32'h1, 1'b0, 1'b0, 32'h0100_0000, 1'b0, 1'b0, 1'b0);
      directed("carry_ovf", 32'h7FFF_FFFF, 32'h0, 1'b1, 1'b0, 32'h8000_0000, 1'b0, 1'b1, 1'b0);

      // Back-to-back streaming with no backpressure.
      rx0 = n_rx;
      for (int i = 0; i < 100; i++) begin
         rand_beat();
         bus.in_valid = 1'b1;
         @(negedge clk);
         check("stream_in_ready", 64'(bus.in_ready), 64'd1);
         if (i >= ST) check("stream_out_valid", 64'(bus.out_valid), 64'd1);
         @(posedge clk); #1;
      end
      bus.in_valid = 1'b0;
      drain("stream", rx0, 100);

      // Stall the output; only STAGES beats fit.
      rx0 = n_rx;
      bus.out_ready = 1'b0;
      bus.in_valid  = 1'b1;
      rand_beat();
      acc_cnt = 0;
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         acc = bus.in_valid & bus.in_ready;
         @(posedge clk); #1;
         if (acc) begin
            acc_cnt++;
            rand_beat();
         end
      end
      check("bp_accepted", 64'(acc_cnt), 64'(ST));
      check("bp_in_ready", 64'(bus.in_ready), 64'd0);
      bus.out_ready = 1'b1;
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         acc = bus.in_valid & bus.in_ready;
         @(posedge clk); #1;
         if (acc) begin
            acc_cnt++;
            rand_beat();
         end
      end
      bus.in_valid = 1'b0;
      drain("bp", rx0, acc_cnt);

      // Reset with three beats in flight.
      for (int i = 0; i < 3; i++) begin
         rand_beat();
         bus.in_valid = 1'b1;
         @(posedge clk); #1;
      end
      bus.in_valid = 1'b0;
      rst_n = 1'b0;
      #1;
      check("midrst_out_valid", 64'(bus.out_valid), 64'd0);
      check("midrst_flags", 64'({bus.cout, bus.ovf, bus.zero}), 64'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      repeat (8) @(posedge clk);
      #1;
      directed("post_rst", 32'h1234_5678, 32'h1111_1111, 1'b1, 1'b0, 32'h2345_678A, 1'b0, 1'b0, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
